// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the multiport synchronous RAM.
// Byte-lane merge is sized for the widest supported word.
package sync_ram_pkg;

  typedef enum logic {
    READ_OLD    = 1'b0,
    WRITE_FIRST = 1'b1
  } rw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (strb[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ram_read_pipe.sv
// Delay line for one read port: STAGES registers of {valid, data}.
// Data only advances with valid, so the output holds between reads.
module sync_ram_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stage_valid,
  input  logic [DATA_WIDTH-1:0] stage_data,
  output logic                  pipe_valid,
  output logic [DATA_WIDTH-1:0] pipe_data
);

  if (STAGES == 0) begin : g_wire
    assign pipe_valid = stage_valid;
    assign pipe_data  = stage_data;
  end else begin : g_regs
    logic [STAGES-1:0]     v;
    logic [DATA_WIDTH-1:0] d [STAGES];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v <= '0;
        for (int i = 0; i < STAGES; i++) d[i] <= '0;
      end else begin
        v[0] <= stage_valid;
        if (stage_valid) d[0] <= stage_data;
        for (int i = 1; i < STAGES; i++) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end

    assign pipe_valid = v[STAGES-1];
    assign pipe_data  = d[STAGES-1];
  end

endmodule

// File: rtl/sync_ram_multiport.sv
// Synchronous RAM: one byte-strobed write port, N read ports,
// configurable read latency, optional zeroing sweep after reset.
module sync_ram_multiport
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int NUM_READ_PORTS = 2,
  parameter int READ_LATENCY   = 1,
  parameter int RW_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  output logic                                 init_busy,
  input  logic [ADDR_WIDTH-1:0]                waddr,
  input  logic [DATA_WIDTH/8-1:0]              wstrb,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic [NUM_READ_PORTS-1:0]            ren,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ_PORTS-1:0]            rvalid
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam rw_mode_e MODE =
    (RW_MODE == 1) ? WRITE_FIRST : READ_OLD;
  localparam init_state_e RST_STATE =
    (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] o,
    input logic [DATA_WIDTH-1:0] n,
    input logic [STRB_WIDTH-1:0] s
  );
    return DATA_WIDTH'(strb_merge(
      MAX_DATA_WIDTH'(o),
      MAX_DATA_WIDTH'(n),
      MAX_STRB_WIDTH'(s)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  init_state_e           state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready;
  logic                  wr_en;

  assign ready = (state == READY);
  assign wr_en = ready && (wstrb != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RST_STATE;
      clr_addr  <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  // Array has no reset; the sweep owns the write port while clearing.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= merge(mem[waddr], wdata, wstrb);
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] fwd;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  hit;

    assign a    = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign word = mem[a];
    assign hit  = (MODE == WRITE_FIRST) && wr_en && (a == waddr);
    assign fwd  = hit ? merge(word, wdata, wstrb) : word;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s_valid <= 1'b0;
        s_data  <= '0;
      end else begin
        s_valid <= ren[p] && ready;
        if (ren[p] && ready) s_data <= fwd;
      end
    end

    sync_ram_read_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (READ_LATENCY - 1)
    ) u_pipe (
      .clock       (clock),
      .reset       (reset),
      .stage_valid (s_valid),
      .stage_data  (s_data),
      .pipe_valid  (rvalid[p]),
      .pipe_data   (rdata[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_sync_ram_multiport.sv
// Two RAM instances share stimulus: latency 1 / READ_OLD and
// latency 3 / WRITE_FIRST, each checked against its own queues.
module tb_sync_ram_multiport;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  waddr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  ren   = '0;
  logic [7:0]  raddr = '0;

  logic        busy_a, busy_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rvalid_a, rvalid_b;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  logic [31:0] model [16];
  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  exp_t mon_e;
  bit   mon_ok;

  sync_ram_multiport #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ_PORTS(2),
    .READ_LATENCY(1), .RW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset(reset), .init_busy(busy_a),
    .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .ren(ren), .raddr(raddr),
    .rdata(rdata_a), .rvalid(rvalid_a)
  );

  sync_ram_multiport #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ_PORTS(2),
    .READ_LATENCY(3), .RW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clock(clock), .reset(reset), .init_busy(busy_b),
    .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .ren(ren), .raddr(raddr),
    .rdata(rdata_b), .rvalid(rvalid_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected finish", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] lane_merge(
    input logic [31:0] o, input logic [31:0] n,
    input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input bit ok,
                     input logic [31:0] d, input exp_t e);
    vectors++;
    assert ({ok, d, cyc} === {1'b1, e.data, e.cyc}) else begin
      fails++;
      $error("FAIL %s got=%h@%0d queued=%0d expected=%h@%0d",
             tag, d, cyc, ok, e.data, e.cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rvalid_a[0]) begin
        mon_ok = qa0.size() > 0;
        mon_e  = mon_ok ? qa0.pop_front() : '{32'h0, -1};
        chk("a_p0", mon_ok, rdata_a[31:0], mon_e);
      end
      if (rvalid_a[1]) begin
        mon_ok = qa1.size() > 0;
        mon_e  = mon_ok ? qa1.pop_front() : '{32'h0, -1};
        chk("a_p1", mon_ok, rdata_a[63:32], mon_e);
      end
      if (rvalid_b[0]) begin
        mon_ok = qb0.size() > 0;
        mon_e  = mon_ok ? qb0.pop_front() : '{32'h0, -1};
        chk("b_p0", mon_ok, rdata_b[31:0], mon_e);
      end
      if (rvalid_b[1]) begin
        mon_ok = qb1.size() > 0;
        mon_e  = mon_ok ? qb1.pop_front() : '{32'h0, -1};
        chk("b_p1", mon_ok, rdata_b[63:32], mon_e);
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input logic [3:0] wa, input logic [3:0] ws,
                       input logic [31:0] wd, input logic [1:0] re,
                       input logic [3:0] a0, input logic [3:0] a1);
    logic [3:0]  a;
    logic [31:0] old, nw;
    waddr = wa; wstrb = ws; wdata = wd;
    ren = re; raddr = {a1, a0};
    for (int p = 0; p < 2; p++) begin
      if (re[p]) begin
        a   = (p == 0) ? a0 : a1;
        old = model[a];
        nw  = (ws != 0 && a == wa) ? lane_merge(old, wd, ws) : old;
        if (p == 0) begin
          qa0.push_back('{old, cyc + 1});
          qb0.push_back('{nw, cyc + 3});
        end else begin
          qa1.push_back('{old, cyc + 1});
          qb1.push_back('{nw, cyc + 3});
        end
      end
    end
    if (ws != 0) model[wa] = lane_merge(model[wa], wd, ws);
    @(negedge clock);
    wstrb = '0; ren = '0;
  endtask

  task automatic wait_ready(output int n, output bit saw);
    n = 0; saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      n++;
      #1;
      if (rvalid_a != 0 || rvalid_b != 0) saw = 1'b1;
      if (!busy_a) break;
    end
  endtask

  int n;
  bit saw;

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {62'h0, busy_a, busy_b}, 64'h3);
    check("rst_rvalid", {60'h0, rvalid_a, rvalid_b}, 64'h0);
    check("rst_rdata_a", rdata_a, 64'h0);
    check("rst_rdata_b", rdata_b, 64'h0);

    // Write and reads attempted all through the sweep.
    waddr = 4'd0; wstrb = 4'hf; wdata = 32'hffffffff;
    ren = 2'b11; raddr = 8'h00;
    reset = 1'b0;
    wait_ready(n, saw);
    wstrb = '0; ren = '0;
    check("sweep_len", 64'(n), 64'd16);
    check("sweep_rvalid", {63'h0, saw}, 64'h0);
    check("busy_b_done", {63'h0, busy_b}, 64'h0);
    @(negedge clock);

    for (int a = 0; a < 16; a++)
      drive(0, 0, 0, 2'b11, 4'(a), 4'(15 - a));

    drive(4'd2, 4'hf, 32'h12345678, 2'b00, 0, 0);
    drive(4'd15, 4'hf, 32'hcafef00d, 2'b01, 4'd2, 0);
    repeat (4) @(negedge clock);

    // Restart mid-sweep.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_ready(n, saw);
    check("restart_len", 64'(n), 64'd16);
    check("restart_rvalid", {63'h0, saw}, 64'h0);
    @(negedge clock);
    for (int i = 0; i < 16; i++) model[i] = '0;
    drive(0, 0, 0, 2'b11, 4'd2, 4'd15);
    drive(0, 0, 0, 2'b11, 4'd0, 4'd7);

    // Byte strobes.
    drive(4'd0, 4'hf, 32'hdeadbeef, 0, 0, 0);
    drive(4'd1, 4'h3, 32'hdeadbeef, 0, 0, 0);
    drive(4'd2, 4'hc, 32'hdeadbeef, 0, 0, 0);
    drive(4'd3, 4'h1, 32'hdeadbeef, 0, 0, 0);
    drive(4'd4, 4'h2, 32'hdeadbeef, 0, 0, 0);

    // Back-to-back reads on both ports.
    for (int a = 0; a < 5; a++)
      drive(0, 0, 0, 2'b11, 4'(a), 4'(4 - a));

    // Same-address collision, then follow-up read.
    drive(4'd5, 4'hf, 32'h11223344, 0, 0, 0);
    drive(4'd5, 4'h3, 32'haabbccdd, 2'b11, 4'd5, 4'd5);
    drive(0, 0, 0, 2'b01, 4'd5, 0);

    drive(0, 0, 0, 2'b11, 4'd0, 4'd1);
    drive(0, 0, 0, 2'b11, 4'd0, 4'd0);

    repeat (6) @(negedge clock);
    check("drain", 64'(qa0.size() + qa1.size()
                     + qb0.size() + qb1.size()), 64'd0);
    check("hold_a", rdata_a, {32'hdeadbeef, 32'hdeadbeef});
    check("hold_b", rdata_b, {32'hdeadbeef, 32'hdeadbeef});

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
